// File: rtl/spi_arbiter_pkg.sv
// spi_arbiter_pkg: state encoding, default watchdog limit and clog2 helper
package spi_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } state_t;
  localparam logic [15:0] DEF_TIMEOUT = 16'hFFFF;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector starting one past last_gnt
module rr_pick
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_gnt,
  output logic            valid,
  output logic [IW-1:0]   index
);
  always_comb begin
    valid = 1'b0;
    index = '0;
    // Scan from farthest to nearest so the nearest set bit wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (|(req & (NREQ'(1) << ((int'(last_gnt) + 1 + i) % NREQ)))) begin
        valid = 1'b1;
        index = IW'((int'(last_gnt) + 1 + i) % NREQ);
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_core between NREQ requesters
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int START_LEN = 4,
  parameter int TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0] TIMEOUT = TO_WIDTH'(DEF_TIMEOUT),
  localparam int IW = clog2(NREQ)
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST_N,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] DONE,
  output logic [NREQ-1:0] ERR,
  output logic            EXT_START,
  input  logic            SPI_SEN,
  output logic [NREQ-1:0] CS_N,
  output logic            BUSY,
  output logic [IW-1:0]   GNT_ID
);
  state_t state;
  logic sen_m, sen_s, err, pick_v, to_hit;
  logic [TO_WIDTH-1:0] cnt, cnt_sat;
  logic [IW-1:0] last_gnt, pick_id;
  assign to_hit = (TIMEOUT != '0) && (cnt == TIMEOUT);
  assign cnt_sat = &cnt ? cnt : cnt + TO_WIDTH'(1);
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(REQ),
    .last_gnt(last_gnt),
    .valid(pick_v),
    .index(pick_id)
  );
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N)
    if (!BUS_RST_N) {sen_s, sen_m} <= 2'b00;
    else {sen_s, sen_m} <= {sen_m, SPI_SEN};
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      err       <= 1'b0;
      last_gnt  <= IW'(NREQ - 1);
      GNT       <= '0;
      DONE      <= '0;
      ERR       <= '0;
      EXT_START <= 1'b0;
      CS_N      <= '1;
      BUSY      <= 1'b0;
      GNT_ID    <= '0;
    end else begin
      DONE <= '0;
      ERR  <= '0;
      case (state)
        IDLE: if (pick_v) begin
          state     <= START;
          cnt       <= '0;
          err       <= 1'b0;
          GNT       <= NREQ'(1) << pick_id;
          CS_N      <= ~(NREQ'(1) << pick_id);
          GNT_ID    <= pick_id;
          EXT_START <= 1'b1;
          BUSY      <= 1'b1;
        end
        START: if (cnt == TO_WIDTH'(START_LEN - 1)) begin
          state     <= WAIT_BUSY;
          cnt       <= '0;
          EXT_START <= 1'b0;
        end else cnt <= cnt + TO_WIDTH'(1);
        WAIT_BUSY: if (sen_s) begin
          state <= WAIT_DONE;
          cnt   <= '0;
        end else if (to_hit) begin
          state <= RELEASE;
          err   <= 1'b1;
        end else cnt <= cnt_sat;
        WAIT_DONE: if (!sen_s) state <= RELEASE;
        else if (to_hit) begin
          state <= RELEASE;
          err   <= 1'b1;
        end else cnt <= cnt_sat;
        RELEASE: begin
          state    <= IDLE;
          GNT      <= '0;
          CS_N     <= '1;
          BUSY     <= 1'b0;
          last_gnt <= GNT_ID;
          DONE     <= err ? '0 : NREQ'(1) << GNT_ID;
          ERR      <= err ? NREQ'(1) << GNT_ID : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
